// File: rtl/bsg_cache_sbuf_drain_ctrl.sv
// bsg_cache_sbuf_drain_ctrl: arbitrates the single data-memory port between load-pipeline
// reads and store-buffer drain writes, with a starvation guard for pending stores, and
// sequences a flush that blocks loads until the store buffer is truly empty.
// Optional performance counters are enabled with BSG_CACHE_SBUF_DRAIN_CTRL_PERF_EN.

module bsg_cache_sbuf_drain_ctrl #(
  parameter int unsigned max_stall_p  = 4,
  parameter int unsigned perf_width_p = 32
) (
  input  logic clk_i,
  input  logic reset_i,

  input  logic ld_v_i,
  output logic ld_yumi_o,

  input  logic sbuf_v_i,
  input  logic sbuf_empty_i,
  output logic sbuf_yumi_o,
  output logic sbuf_bypass_v_o,

  input  logic dmem_ready_i,
  output logic dmem_v_o,
  output logic dmem_w_o,

  input  logic flush_v_i,
  output logic flush_ready_o,
  output logic flush_done_o
`ifdef BSG_CACHE_SBUF_DRAIN_CTRL_PERF_EN
  ,
  output logic [perf_width_p-1:0] drain_count_o,
  output logic [perf_width_p-1:0] starve_count_o
`endif
);

  localparam int unsigned StallW = $clog2(max_stall_p + 1);
  localparam logic [StallW-1:0] MaxStall = StallW'(max_stall_p);

  typedef enum logic [1:0] {
    StNormal,
    StFlush,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [StallW-1:0] stall_q, stall_d;

  logic ld_grant;
  logic st_grant;
  logic flush_ready;
  logic flush_done;

  // Next-state and grant logic; everything is forced low while reset is held.
  always_comb begin
    ld_grant    = 1'b0;
    st_grant    = 1'b0;
    flush_ready = 1'b0;
    flush_done  = 1'b0;
    state_d     = state_q;
    stall_d     = stall_q;

    unique case (state_q)
      StNormal, StDone: begin
        if (dmem_ready_i) begin
          // Loads win until the store has lost max_stall_p times in a row.
          if (ld_v_i && (stall_q < MaxStall)) begin
            ld_grant = 1'b1;
          end else if (sbuf_v_i) begin
            st_grant = 1'b1;
          end else if (ld_v_i) begin
            ld_grant = 1'b1;
          end
        end
        if (state_q == StNormal) begin
          flush_ready = 1'b1;
          if (flush_v_i) state_d = StFlush;
        end else begin
          flush_done = 1'b1;
          state_d    = StNormal;
        end
      end
      StFlush: begin
        st_grant = sbuf_v_i & dmem_ready_i;
        // Only a true empty with no drain in flight completes the flush.
        if (sbuf_empty_i && !st_grant) state_d = StDone;
      end
      default: state_d = StNormal;
    endcase

    if (state_q == StFlush) begin
      stall_d = '0;
    end else if (sbuf_v_i && ld_grant) begin
      stall_d = (stall_q == MaxStall) ? stall_q : stall_q + 1'b1;
    end else if (st_grant || !sbuf_v_i) begin
      stall_d = '0;
    end

    if (reset_i) begin
      ld_grant    = 1'b0;
      st_grant    = 1'b0;
      flush_ready = 1'b0;
      flush_done  = 1'b0;
    end
  end

  // State and stall counter registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StNormal;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
    end
  end

  assign ld_yumi_o       = ld_grant;
  assign sbuf_yumi_o     = st_grant;
  assign sbuf_bypass_v_o = ld_grant;
  assign dmem_v_o        = ld_grant | st_grant;
  assign dmem_w_o        = st_grant;
  assign flush_ready_o   = flush_ready;
  assign flush_done_o    = flush_done;

`ifdef BSG_CACHE_SBUF_DRAIN_CTRL_PERF_EN
  logic [perf_width_p-1:0] drain_count_q;
  logic [perf_width_p-1:0] starve_count_q;

  // Drain and force-grant counters; both wrap naturally.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      drain_count_q  <= '0;
      starve_count_q <= '0;
    end else begin
      if (st_grant) drain_count_q <= drain_count_q + 1'b1;
      if (st_grant && ld_v_i) starve_count_q <= starve_count_q + 1'b1;
    end
  end

  assign drain_count_o  = drain_count_q;
  assign starve_count_o = starve_count_q;
`endif

endmodule

// File: tb/tb_bsg_cache_sbuf_drain_ctrl.sv
// Testbench for bsg_cache_sbuf_drain_ctrl: directed scenarios plus a randomized run
// checked against a behavioural model of the arbitration and flush rules.

module tb_bsg_cache_sbuf_drain_ctrl;

  localparam int MaxStall = 4;
  localparam int PerfW    = 32;

  logic clk;
  logic reset_i, ld_v_i, sbuf_v_i, sbuf_empty_i, dmem_ready_i, flush_v_i;
  logic ld_yumi_o, sbuf_yumi_o, sbuf_bypass_v_o, dmem_v_o, dmem_w_o;
  logic flush_ready_o, flush_done_o;
`ifdef BSG_CACHE_SBUF_DRAIN_CTRL_PERF_EN
  logic [PerfW-1:0] drain_count_o, starve_count_o;
`endif

  logic [6:0] outs;
  assign outs = {ld_yumi_o, sbuf_yumi_o, sbuf_bypass_v_o, dmem_v_o, dmem_w_o,
                 flush_ready_o, flush_done_o};

  int n_checks = 0;
  int n_fail   = 0;

  bsg_cache_sbuf_drain_ctrl #(
    .max_stall_p (MaxStall),
    .perf_width_p(PerfW)
  ) dut (
    .clk_i          (clk),
    .reset_i        (reset_i),
    .ld_v_i         (ld_v_i),
    .ld_yumi_o      (ld_yumi_o),
    .sbuf_v_i       (sbuf_v_i),
    .sbuf_empty_i   (sbuf_empty_i),
    .sbuf_yumi_o    (sbuf_yumi_o),
    .sbuf_bypass_v_o(sbuf_bypass_v_o),
    .dmem_ready_i   (dmem_ready_i),
    .dmem_v_o       (dmem_v_o),
    .dmem_w_o       (dmem_w_o),
    .flush_v_i      (flush_v_i),
    .flush_ready_o  (flush_ready_o),
    .flush_done_o   (flush_done_o)
`ifdef BSG_CACHE_SBUF_DRAIN_CTRL_PERF_EN
    ,
    .drain_count_o  (drain_count_o),
    .starve_count_o (starve_count_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply inputs just after a falling edge and let combinational outputs settle.
  task automatic tick(input logic rst, input logic ld, input logic sv, input logic emp,
                      input logic rdy, input logic fl);
    @(negedge clk);
    reset_i      = rst;
    ld_v_i       = ld;
    sbuf_v_i     = sv;
    sbuf_empty_i = emp;
    dmem_ready_i = rdy;
    flush_v_i    = fl;
    #1;
  endtask

  task automatic do_reset();
    tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      n_checks++;
      if (outs !== 7'b0) begin
        n_fail++;
        $display("FAIL reset_outputs cycle %0d: got %b expected 0000000", i, outs);
      end
    end
    tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if ({ld_yumi_o, sbuf_yumi_o, dmem_w_o, sbuf_bypass_v_o, flush_ready_o} !== 5'b10011) begin
      n_fail++;
      $display("FAIL first_after_reset: got ld=%b st=%b w=%b byp=%b fr=%b expected 1 0 0 1 1",
               ld_yumi_o, sbuf_yumi_o, dmem_w_o, sbuf_bypass_v_o, flush_ready_o);
    end
  endtask

  task automatic test_starve();
    logic exp_ld;
    do_reset();
    for (int i = 0; i < 15; i++) begin
      tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      exp_ld = ((i % (MaxStall + 1)) < MaxStall);
      n_checks++;
      if (ld_yumi_o !== exp_ld || sbuf_yumi_o !== !exp_ld) begin
        n_fail++;
        $display("FAIL starve_pattern cycle %0d: got ld=%b st=%b expected ld=%b st=%b",
                 i, ld_yumi_o, sbuf_yumi_o, exp_ld, !exp_ld);
      end
    end
  endtask

  task automatic test_not_ready();
    do_reset();
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (ld_yumi_o !== 1'b0 || sbuf_yumi_o !== 1'b0 || dmem_v_o !== 1'b0) begin
        n_fail++;
        $display("FAIL not_ready cycle %0d: got ld=%b st=%b v=%b expected 0 0 0",
                 i, ld_yumi_o, sbuf_yumi_o, dmem_v_o);
      end
    end
    // Three loads won before the stall; one more load, then the store must win.
    tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (ld_yumi_o !== 1'b1 || sbuf_yumi_o !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_again_load: got ld=%b st=%b expected 1 0", ld_yumi_o, sbuf_yumi_o);
    end
    tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (ld_yumi_o !== 1'b0 || sbuf_yumi_o !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_again_store: got ld=%b st=%b expected 0 1", ld_yumi_o, sbuf_yumi_o);
    end
  endtask

  task automatic test_flush_drain();
    do_reset();
    tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    n_checks++;
    if (ld_yumi_o !== 1'b1 || sbuf_yumi_o !== 1'b0 || flush_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_accept: got ld=%b st=%b fr=%b expected 1 0 1",
               ld_yumi_o, sbuf_yumi_o, flush_ready_o);
    end
    for (int i = 0; i < 2; i++) begin
      tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      n_checks++;
      if ({ld_yumi_o, sbuf_yumi_o, dmem_w_o, flush_ready_o, flush_done_o} !== 5'b01100) begin
        n_fail++;
        $display("FAIL flush_drain cycle %0d: got ld=%b st=%b w=%b fr=%b done=%b expected 0 1 1 0 0",
                 i, ld_yumi_o, sbuf_yumi_o, dmem_w_o, flush_ready_o, flush_done_o);
      end
    end
    tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (ld_yumi_o !== 1'b0 || flush_done_o !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_empty_cycle: got ld=%b done=%b expected 0 0", ld_yumi_o, flush_done_o);
    end
    tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (flush_done_o !== 1'b1 || ld_yumi_o !== 1'b1 || flush_ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_done: got done=%b ld=%b fr=%b expected 1 1 0",
               flush_done_o, ld_yumi_o, flush_ready_o);
    end
    tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (flush_done_o !== 1'b0 || ld_yumi_o !== 1'b1 || flush_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL after_done: got done=%b ld=%b fr=%b expected 0 1 1",
               flush_done_o, ld_yumi_o, flush_ready_o);
    end
  endtask

  task automatic test_flush_empty();
    logic [2:0] exp_fd [4];
    exp_fd[0] = 3'b100;  // accept cycle: fr=1
    exp_fd[1] = 3'b000;  // FLUSH
    exp_fd[2] = 3'b001;  // DONE
    exp_fd[3] = 3'b100;  // NORMAL
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, (i == 0));
      n_checks++;
      if ({flush_ready_o, sbuf_yumi_o, flush_done_o} !== exp_fd[i]) begin
        n_fail++;
        $display("FAIL flush_empty cycle %0d: got fr/st/done=%b expected %b",
                 i, {flush_ready_o, sbuf_yumi_o, flush_done_o}, exp_fd[i]);
      end
    end
  endtask

  task automatic test_reset_mid_flush();
    do_reset();
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (flush_ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL in_flush_ready: got %b expected 0", flush_ready_o);
    end
    tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (outs !== 7'b0) begin
      n_fail++;
      $display("FAIL mid_flush_reset: got %b expected 0000000", outs);
    end
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (flush_done_o !== 1'b0 || flush_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_state: got done=%b fr=%b expected 0 1",
               flush_done_o, flush_ready_o);
    end
`ifdef BSG_CACHE_SBUF_DRAIN_CTRL_PERF_EN
    n_checks++;
    if (drain_count_o !== '0 || starve_count_o !== '0) begin
      n_fail++;
      $display("FAIL perf_after_reset: got drain=%0d starve=%0d expected 0 0",
               drain_count_o, starve_count_o);
    end
`endif
  endtask

  // Randomized run: a store-buffer occupancy model feeds the DUT, and a rule-level model
  // predicts every grant, flush handshake and done pulse.
  task automatic test_random();
    int  mode;     // 0 = accepting flushes, 1 = draining for flush, 2 = flush-done cycle
    int  losses;   // consecutive times a waiting store lost to a load
    int  occ;      // store buffer occupancy
    int  drains, starves;
    logic rst, ld, rdy, fl, sv, emp;
    logic e_ld, e_st, e_fr, e_dn;
    do_reset();
    mode = 0; losses = 0; occ = 0; drains = 0; starves = 0;
    for (int c = 0; c < 800; c++) begin
      rst = ($urandom_range(0, 59) == 0);
      ld  = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 3) != 0);
      fl  = ($urandom_range(0, 11) == 0);
      sv  = (occ > 0);
      emp = (occ == 0);
      tick(rst, ld, sv, emp, rdy, fl);

      e_ld = 0; e_st = 0; e_fr = 0; e_dn = 0;
      if (!rst) begin
        e_fr = (mode == 0);
        e_dn = (mode == 2);
        if (rdy) begin
          if (mode == 1) e_st = sv;
          else if (ld && (losses < MaxStall || !sv)) e_ld = 1;
          else if (sv) e_st = 1;
        end
      end

      n_checks++;
      if ({ld_yumi_o, sbuf_yumi_o, sbuf_bypass_v_o, dmem_v_o, dmem_w_o, flush_ready_o,
           flush_done_o} !== {e_ld, e_st, e_ld, e_ld | e_st, e_st, e_fr, e_dn}) begin
        n_fail++;
        $display("FAIL random cycle %0d: got ld/st/byp/v/w/fr/done=%b expected %b",
                 c, outs, {e_ld, e_st, e_ld, e_ld | e_st, e_st, e_fr, e_dn});
      end
`ifdef BSG_CACHE_SBUF_DRAIN_CTRL_PERF_EN
      n_checks++;
      if (drain_count_o !== PerfW'(drains) || starve_count_o !== PerfW'(starves)) begin
        n_fail++;
        $display("FAIL random_perf cycle %0d: got drain=%0d starve=%0d expected %0d %0d",
                 c, drain_count_o, starve_count_o, drains, starves);
      end
`endif

      if (rst) begin
        mode = 0; losses = 0; drains = 0; starves = 0;
      end else begin
        if (e_st) drains++;
        if (e_st && ld) starves++;
        if (mode == 1) losses = 0;
        else if (sv && e_ld) losses = (losses < MaxStall) ? losses + 1 : losses;
        else if (e_st || !sv) losses = 0;
        case (mode)
          0: mode = fl ? 1 : 0;
          1: mode = (emp && !e_st) ? 2 : 1;
          default: mode = 0;
        endcase
      end
      if (e_st) occ--;
      if (occ < 4 && $urandom_range(0, 2) == 0) occ++;
    end
  endtask

  initial begin
    reset_i = 1; ld_v_i = 0; sbuf_v_i = 0; sbuf_empty_i = 1; dmem_ready_i = 0; flush_v_i = 0;
    test_reset();
    test_starve();
    test_not_ready();
    test_flush_drain();
    test_flush_empty();
    test_reset_mid_flush();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bsg_cache_sbuf_drain_ctrl.md
Name: bsg_cache_sbuf_drain_ctrl

Overview:
Arbitration and sequencing controller for the cache store buffer's drain path. Shares the single data-memory port between the load pipeline (reads) and store-buffer drains (writes), with a starvation guard for stores. Also sequences a flush that blocks loads until the store buffer is empty. Sits between the cache pipeline, the store buffer and the data SRAM port.

Parameters:
max_stall_p, 4, consecutive cycles a pending store may lose to loads before it is force-granted (>=1)
perf_width_p, 32, width of the performance counters (optional feature only)

Ports:
clk_i  in  1  clock
reset_i  in  1  reset; synchronous, active-high
ld_v_i  in  1  load pipeline requests the data-memory port this cycle
ld_yumi_o  out  1  load granted; the load uses the port this cycle
sbuf_v_i  in  1  store buffer has a head entry (store buffer v_o)
sbuf_empty_i  in  1  store buffer empty (store buffer empty_o)
sbuf_yumi_o  out  1  dequeue the store buffer head; the write uses the port this cycle
sbuf_bypass_v_o  out  1  bypass strobe to the store buffer; equals ld_yumi_o
dmem_ready_i  in  1  data-memory port can accept an access this cycle
dmem_v_o  out  1  data-memory access valid
dmem_w_o  out  1  1 = write (store drain), 0 = read (load)
flush_v_i  in  1  flush request
flush_ready_o  out  1  flush request accepted when flush_v_i & flush_ready_o
flush_done_o  out  1  one-cycle pulse: flush complete

Behaviour:
- State register: NORMAL, FLUSH, DONE. Reset -> NORMAL. Stall counter stall_r is $clog2(max_stall_p+1) bits; reset -> 0.
- While reset_i=1, all outputs are 0, independent of the inputs.
- All grants are combinational, in the same cycle. If dmem_ready_i=0, then ld_yumi_o=0 and sbuf_yumi_o=0.
- ld_yumi_o and sbuf_yumi_o are never both 1.
- dmem_v_o = ld_yumi_o | sbuf_yumi_o.
- dmem_w_o = sbuf_yumi_o.
- sbuf_bypass_v_o = ld_yumi_o.
- NORMAL, dmem_ready_i=1:
  - If ld_v_i and stall_r < max_stall_p: grant the load.
  - Else if sbuf_v_i: grant the store.
  - Else if ld_v_i: grant the load (starve limit reached but no store pending).
- stall_r update:
  - sbuf_v_i & ld_yumi_o: stall_r+1, saturating at max_stall_p.
  - sbuf_yumi_o, or sbuf_v_i=0: stall_r = 0.
  - Otherwise: hold.
- Starve guarantee: after max_stall_p consecutive load grants with a store pending, the next ready cycle grants the store.
- flush_ready_o = 1 only in NORMAL (and not in reset).
- NORMAL -> FLUSH on flush_v_i & flush_ready_o. Arbitration in that same cycle still follows NORMAL rules.
- FLUSH:
  - ld_yumi_o = 0.
  - sbuf_yumi_o = sbuf_v_i & dmem_ready_i.
  - stall_r held at 0.
  - FLUSH -> DONE when sbuf_empty_i=1 and sbuf_yumi_o=0 in the same cycle.
  - A flush with an already-empty buffer reaches DONE the cycle after acceptance.
- DONE:
  - flush_done_o = 1 for exactly this one cycle.
  - Arbitration follows NORMAL rules.
  - flush_ready_o = 0.
  - DONE -> NORMAL unconditionally.
- Store entries enqueued by the pipeline during FLUSH are drained as well. The flush completes only at a true empty.
- Reset asserted mid-flush: return to NORMAL, stall_r=0, no flush_done_o pulse.

Optional Feature:
Macro: BSG_CACHE_SBUF_DRAIN_CTRL_PERF_EN
- Defined: adds outputs drain_count_o [perf_width_p-1:0] and starve_count_o [perf_width_p-1:0].
  - drain_count_o increments on every sbuf_yumi_o.
  - starve_count_o increments on every store force-grant (store granted while ld_v_i=1).
  - Both reset to 0 and wrap modulo 2^perf_width_p.
- Not defined: the ports and counters do not exist. Arbitration behaviour is identical in both cases.

Test Plan:
1. Reset held 2 cycles with ld_v_i=sbuf_v_i=flush_v_i=1 -> all outputs 0. First cycle after reset (NORMAL) with dmem_ready_i=1 -> ld_yumi_o=1, dmem_w_o=0, sbuf_bypass_v_o=1.
2. max_stall_p=4, ld_v_i=1 and sbuf_v_i=1 held, dmem_ready_i=1 -> grant pattern L,L,L,L,S repeating. stall_r sequence is 1,2,3,4,0.
3. dmem_ready_i=0 for 3 cycles with both requesting -> no grants and stall_r unchanged. Then ready=1 -> the load is granted.
4. Store buffer holds 2 entries, flush_v_i pulsed with ld_v_i=1 throughout:
   - Acceptance cycle: load granted.
   - Next 2 cycles: store grants only.
   - Then sbuf_empty_i=1 -> flush_done_o pulses 1 cycle later.
   - Following cycle: load granted again.
5. Flush with sbuf_empty_i=1 already -> flush_done_o asserted exactly 2 cycles after acceptance (NORMAL -> FLUSH -> DONE). flush_ready_o=0 during FLUSH and DONE.
6. reset_i asserted while in FLUSH with 1 entry pending -> no flush_done_o; the next cycle is NORMAL with flush_ready_o=1. With PERF_EN, the counters read 0.
